// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer: sequencer states,
// MIPS opcode/field constants and instruction field slicers.
package pc_sequencer_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_e;

    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;

    localparam logic [4:0] RT_BLTZ = 5'd0;
    localparam logic [4:0] RT_BGEZ = 5'd1;
    localparam logic [4:0] REG_RA  = 5'd31;

    function automatic logic [5:0] fld_op(input logic [31:0] ins);
        return ins[31:26];
    endfunction

    function automatic logic [4:0] fld_rs(input logic [31:0] ins);
        return ins[25:21];
    endfunction

    function automatic logic [4:0] fld_rt(input logic [31:0] ins);
        return ins[20:16];
    endfunction

    function automatic logic [15:0] fld_imm(input logic [31:0] ins);
        return ins[15:0];
    endfunction

    function automatic logic [25:0] fld_addr(input logic [31:0] ins);
        return ins[25:0];
    endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: pushing when full overwrites the oldest
// entry, popping when empty leaves pointer and count untouched.
module ras_stack #(
    parameter int AW        = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [AW-1:0] i_push_data,
    output logic [AW-1:0] o_top,
    output logic          o_valid,
    output logic [AW-1:0] o_pop_data
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [AW-1:0] r_mem [RAS_DEPTH];
    logic [PW-1:0] r_ptr;
    logic [CW-1:0] r_count;
    logic [PW-1:0] w_top_idx;

    // r_ptr is the next free slot; the newest entry sits just below it.
    assign w_top_idx  = r_ptr - PW'(1);
    assign o_valid    = (r_count != '0);
    assign o_pop_data = r_mem[w_top_idx];
    assign o_top      = o_valid ? o_pop_data : '0;

    // NOTE: the storage array has no reset; r_count alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_ptr] <= i_push_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= '0;
            r_count <= '0;
        end else if (i_push) begin
            r_ptr <= r_ptr + PW'(1);
            if (r_count != CW'(RAS_DEPTH)) begin
                r_count <= r_count + CW'(1);
            end
        end else if (i_pop && o_valid) begin
            r_ptr   <= w_top_idx;
            r_count <= r_count - CW'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC sequencer for the single-cycle MIPS core: branch/jump flow, stall,
// exception halt/vector FSM with EPC and eret, plus a jr $ra return-address predictor.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int            AW         = 32,
    parameter int            DW         = 64,
    parameter logic [AW-1:0] TEXT_START = AW'(32'h0040_0000),
    parameter logic [AW-1:0] EXCP_ADDR  = AW'(32'h8000_0180),
    parameter int            EXCP_MODE  = 0,
    parameter int            RAS_DEPTH  = 4,
    parameter int            CNT_W      = 16
) (
    input  logic             clk_cpu,
    input  logic             reset_n,
    input  logic             stall,
    input  logic [31:0]      inst,
    input  logic             cp_excp,
    input  logic             is_jr,
    input  logic             is_jalr,
    input  logic             eret,
    input  logic [DW-1:0]    alu_result,
    output logic [AW-1:0]    pc,
    output logic [AW-1:0]    epc,
    output logic             halted,
    output logic [AW-1:0]    ras_pred,
    output logic             ras_valid,
    output logic             ras_hit,
    output logic [CNT_W-1:0] ras_miss_cnt
);

    localparam bit VEC_MODE = (EXCP_MODE == 1);

    state_e     r_state, w_state_nxt;
    logic [AW-1:0] r_pc, w_pc_nxt;
    logic [AW-1:0] r_epc, w_epc_nxt;
    logic          r_ras_hit;
    logic [CNT_W-1:0] r_miss_cnt;

    logic [AW-1:0] w_next_addr, w_brnc_addr, w_jmp_addr, w_jr_target, w_flow_pc;
    logic [15:0]   w_imm;
    logic [5:0]    w_op;
    logic          w_alu_neg, w_alu_zero;
    logic          w_excp, w_eret_en, w_flow;
    logic          w_push, w_pop, w_ras_match;
    logic [AW-1:0] w_ras_top, w_pop_data;

    assign w_op        = fld_op(inst);
    assign w_imm       = fld_imm(inst);
    assign w_next_addr = r_pc + AW'(4);
    assign w_brnc_addr = w_next_addr + {{(AW-18){w_imm[15]}}, w_imm, 2'b00};
    assign w_jmp_addr  = {r_pc[AW-1:28], fld_addr(inst), 2'b00};
    assign w_jr_target = alu_result[DW-1 -: AW];
    assign w_alu_neg   = alu_result[DW-1];
    assign w_alu_zero  = (alu_result == '0);

    // A misaligned fetch address faults on the cycle it is presented, stall or not.
    assign w_excp    = (r_state == RUN) && (cp_excp || (r_pc[1:0] != 2'b00));
    assign w_eret_en = eret && VEC_MODE;
    assign w_flow    = (r_state == RUN) && !w_excp && !stall && !w_eret_en;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_flow_pc = w_next_addr;
        if (is_jr || is_jalr) begin
            w_flow_pc = w_jr_target;
        end else begin
            case (w_op)
                OP_REGIMM: begin
                    if ((fld_rt(inst) == RT_BLTZ && w_alu_neg) ||
                        (fld_rt(inst) == RT_BGEZ && !w_alu_neg)) begin
                        w_flow_pc = w_brnc_addr;
                    end
                end
                OP_BEQ:       if (w_alu_zero)               w_flow_pc = w_brnc_addr;
                OP_BNE:       if (!w_alu_zero)              w_flow_pc = w_brnc_addr;
                OP_BLEZ:      if (w_alu_neg || w_alu_zero)  w_flow_pc = w_brnc_addr;
                OP_BGTZ:      if (!w_alu_neg && !w_alu_zero) w_flow_pc = w_brnc_addr;
                OP_J, OP_JAL: w_flow_pc = w_jmp_addr;
                default:      w_flow_pc = w_next_addr;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_epc_nxt   = r_epc;
        case (r_state)
            RUN: begin
                if (w_excp) begin
                    w_pc_nxt    = EXCP_ADDR;
                    w_epc_nxt   = r_pc;
                    w_state_nxt = VEC_MODE ? RUN : HALT;
                end else if (stall) begin
                    w_pc_nxt = r_pc;
                end else if (w_eret_en) begin
                    w_pc_nxt = r_epc + AW'(4);
                end else begin
                    w_pc_nxt = w_flow_pc;
                end
            end
            HALT: w_pc_nxt = EXCP_ADDR;
        endcase
    end

    always_ff @(posedge clk_cpu or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= RUN;
            r_pc    <= TEXT_START;
            r_epc   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_epc   <= w_epc_nxt;
        end
    end

    // Only jr $ra consults the stack; jalr pushes its link but never pops.
    assign w_push      = w_flow && ((w_op == OP_JAL) || is_jalr);
    assign w_pop       = w_flow && is_jr && (fld_rs(inst) == REG_RA);
    assign w_ras_match = ras_valid && (w_pop_data == w_jr_target);

    ras_stack #(
        .AW        (AW),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk_cpu),
        .rst_n       (reset_n),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_push_data (w_next_addr),
        .o_top       (w_ras_top),
        .o_valid     (ras_valid),
        .o_pop_data  (w_pop_data)
    );

    always_ff @(posedge clk_cpu or negedge reset_n) begin
        if (!reset_n) begin
            r_ras_hit  <= 1'b0;
            r_miss_cnt <= '0;
        end else begin
            r_ras_hit <= w_pop && w_ras_match;
            if (w_pop && !w_ras_match && (r_miss_cnt != '1)) begin
                r_miss_cnt <= r_miss_cnt + CNT_W'(1);
            end
        end
    end

    assign pc           = r_pc;
    assign epc          = r_epc;
    assign halted       = (r_state == HALT);
    assign ras_pred     = w_ras_top;
    assign ras_hit      = r_ras_hit;
    assign ras_miss_cnt = r_miss_cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a behavioural model predicts every
// output after each clock; a halt-mode and a vector-mode instance are exercised in turn.
module tb_pc_sequencer;

    localparam logic [31:0] TEXT_START = 32'h0040_0000;
    localparam logic [31:0] EXCP_ADDR  = 32'h8000_0180;
    localparam int          DEPTH      = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] epc;
        logic        halted;
        logic        valid;
        logic [31:0] pred;
        logic        hit;
        logic [15:0] miss;
    } exp_t;

    logic        clk_cpu = 1'b0;
    logic        rst_n0  = 1'b0;
    logic        rst_n1  = 1'b0;
    logic        stall   = 1'b0;
    logic [31:0] inst    = '0;
    logic        cp_excp = 1'b0;
    logic        is_jr   = 1'b0;
    logic        is_jalr = 1'b0;
    logic        eret    = 1'b0;
    logic [63:0] alu_result = '0;

    logic [31:0] pc0, epc0, pred0, pc1, epc1, pred1;
    logic        halted0, valid0, hit0, halted1, valid1, hit1;
    logic [15:0] miss0, miss1;

    always #5 clk_cpu = ~clk_cpu;

    pc_sequencer #(.EXCP_MODE(0)) u_dut_halt (
        .clk_cpu      (clk_cpu),
        .reset_n      (rst_n0),
        .stall        (stall),
        .inst         (inst),
        .cp_excp      (cp_excp),
        .is_jr        (is_jr),
        .is_jalr      (is_jalr),
        .eret         (eret),
        .alu_result   (alu_result),
        .pc           (pc0),
        .epc          (epc0),
        .halted       (halted0),
        .ras_pred     (pred0),
        .ras_valid    (valid0),
        .ras_hit      (hit0),
        .ras_miss_cnt (miss0)
    );

    pc_sequencer #(.EXCP_MODE(1)) u_dut_vec (
        .clk_cpu      (clk_cpu),
        .reset_n      (rst_n1),
        .stall        (stall),
        .inst         (inst),
        .cp_excp      (cp_excp),
        .is_jr        (is_jr),
        .is_jalr      (is_jalr),
        .eret         (eret),
        .alu_result   (alu_result),
        .pc           (pc1),
        .epc          (epc1),
        .halted       (halted1),
        .ras_pred     (pred1),
        .ras_valid    (valid1),
        .ras_hit      (hit1),
        .ras_miss_cnt (miss1)
    );

    // ---------------- model state ----------------
    bit          m_vec;
    logic [31:0] m_pc, m_epc;
    bit          m_halt, m_hit;
    logic [15:0] m_miss;
    logic [31:0] m_ras[$];
    exp_t        sb_q[$];
    int          n_chk = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc   = TEXT_START;
        m_epc  = '0;
        m_halt = 1'b0;
        m_hit  = 1'b0;
        m_miss = '0;
        m_ras.delete();
    endtask

    task automatic bump_miss();
        if (m_miss != 16'hFFFF) m_miss = m_miss + 16'd1;
    endtask

    task automatic model_step(input bit st, input logic [31:0] in, input bit ex,
                              input bit jr, input bit jalr, input bit er, input logic [63:0] alu);
        logic [31:0] seq, br, tgt, npc, popped;
        logic [5:0]  op;
        logic [4:0]  rs, rt;
        bit          take;
        op   = in[31:26];
        rs   = in[25:21];
        rt   = in[20:16];
        seq  = m_pc + 32'd4;
        br   = seq + ({{16{in[15]}}, in[15:0]} << 2);
        tgt  = alu[63:32];
        m_hit = 1'b0;
        if (m_halt) return;
        if (ex || m_pc[1:0] != 2'b00) begin
            m_epc  = m_pc;
            m_pc   = EXCP_ADDR;
            m_halt = !m_vec;
            return;
        end
        if (st) return;
        if (er && m_vec) begin
            m_pc = m_epc + 32'd4;
            return;
        end
        case (op)
            6'd1:    take = (rt == 5'd0 && $signed(alu) < 0) || (rt == 5'd1 && $signed(alu) >= 0);
            6'd4:    take = (alu == 64'd0);
            6'd5:    take = (alu != 64'd0);
            6'd6:    take = ($signed(alu) <= 0);
            6'd7:    take = ($signed(alu) > 0);
            default: take = 1'b0;
        endcase
        npc = take ? br : seq;
        if (op == 6'd2 || op == 6'd3) npc = {m_pc[31:28], in[25:0], 2'b00};
        if (jr || jalr) npc = tgt;
        if (jr && rs == 5'd31) begin
            if (m_ras.size() == 0) begin
                bump_miss();
            end else begin
                popped = m_ras.pop_back();
                if (popped == tgt) m_hit = 1'b1;
                else bump_miss();
            end
        end
        if (op == 6'd3 || jalr) begin
            m_ras.push_back(seq);
            if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
        end
        m_pc = npc;
    endtask

    task automatic push_expect();
        exp_t e;
        e.pc     = m_pc;
        e.epc    = m_epc;
        e.halted = m_halt;
        e.valid  = (m_ras.size() != 0);
        e.pred   = (m_ras.size() != 0) ? m_ras[m_ras.size()-1] : 32'd0;
        e.hit    = m_hit;
        e.miss   = m_miss;
        sb_q.push_back(e);
    endtask

    task automatic compare_out(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            check({tag, ".sb_empty"}, 64'd0, 64'd1);
            return;
        end
        e = sb_q.pop_front();
        check({tag, ".pc"},     m_vec ? pc1     : pc0,     e.pc);
        check({tag, ".epc"},    m_vec ? epc1    : epc0,    e.epc);
        check({tag, ".halted"}, m_vec ? halted1 : halted0, e.halted);
        check({tag, ".valid"},  m_vec ? valid1  : valid0,  e.valid);
        check({tag, ".pred"},   m_vec ? pred1   : pred0,   e.pred);
        check({tag, ".hit"},    m_vec ? hit1    : hit0,    e.hit);
        check({tag, ".miss"},   m_vec ? miss1   : miss0,   e.miss);
    endtask

    task automatic step(input string tag, input bit st, input logic [31:0] in, input bit ex,
                        input bit jr, input bit jalr, input bit er, input logic [63:0] alu);
        @(negedge clk_cpu);
        stall      = st;
        inst       = in;
        cp_excp    = ex;
        is_jr      = jr;
        is_jalr    = jalr;
        eret       = er;
        alu_result = alu;
        model_step(st, in, ex, jr, jalr, er, alu);
        push_expect();
        @(posedge clk_cpu);
        #1;
        compare_out(tag);
    endtask

    // ---------------- instruction encoders ----------------
    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [31:0] target);
        return {op, target[27:2]};
    endfunction

    function automatic logic [31:0] enc_jr(input logic [4:0] rs, input logic [5:0] funct);
        return {6'd0, rs, 15'd0, funct};
    endfunction

    function automatic logic [63:0] tgt(input logic [31:0] a);
        return {a, 32'd0};
    endfunction

    typedef struct {
        logic [31:0] in;
        logic [63:0] alu;
    } br_t;

    br_t br_tab[$];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] jr_ra;
        jr_ra = enc_jr(5'd31, 6'h08);

        // ---- phase A: vector-mode instance ----
        m_vec = 1'b1;
        model_reset();
        @(posedge clk_cpu);
        #1;
        push_expect();
        compare_out("reset_vec");
        rst_n1 = 1'b1;

        for (int i = 0; i < 4; i++) step("nop_seq", 0, 32'd0, 0, 0, 0, 0, 64'd0);

        step("beq_self", 0, enc_i(6'd4, 5'd1, 5'd2, 16'hFFFF), 0, 0, 0, 0, 64'd0);
        step("beq_nt",   0, enc_i(6'd4, 5'd1, 5'd2, 16'hFFFF), 0, 0, 0, 0, 64'd5);
        step("j",        0, enc_j(6'd2, 32'h0040_0020), 0, 0, 0, 0, 64'd0);
        step("jal",      0, enc_j(6'd3, 32'h0040_0040), 0, 0, 0, 0, 64'd0);
        step("jr_hit",   0, jr_ra, 0, 1, 0, 0, tgt(32'h0040_0024));
        step("nop",      0, 32'd0, 0, 0, 0, 0, 64'd0);
        step("jal2",     0, enc_j(6'd3, 32'h0040_0080), 0, 0, 0, 0, 64'd0);
        step("jr_miss",  0, jr_ra, 0, 1, 0, 0, tgt(32'h0040_0100));

        for (int i = 0; i < 5; i++)
            step("jal_fill", 0, enc_j(6'd3, 32'h0040_0200 + 32'(i) * 32'h100), 0, 0, 0, 0, 64'd0);
        for (int i = 0; i < 5; i++)
            step("jr_lifo", 0, jr_ra, 0, 1, 0, 0, tgt(32'h0040_0504 - 32'(i) * 32'h100));

        br_tab.push_back('{enc_i(6'd5, 5'd1, 5'd2, 16'd8),      64'd0});
        br_tab.push_back('{enc_i(6'd5, 5'd1, 5'd2, 16'd8),      64'd1});
        br_tab.push_back('{enc_i(6'd6, 5'd1, 5'd0, 16'd4),      64'd0});
        br_tab.push_back('{enc_i(6'd6, 5'd1, 5'd0, 16'hFFFE),   64'hFFFF_FFFF_FFFF_FFFF});
        br_tab.push_back('{enc_i(6'd6, 5'd1, 5'd0, 16'd4),      64'd1});
        br_tab.push_back('{enc_i(6'd7, 5'd1, 5'd0, 16'd6),      64'd1});
        br_tab.push_back('{enc_i(6'd7, 5'd1, 5'd0, 16'd6),      64'd0});
        br_tab.push_back('{enc_i(6'd7, 5'd1, 5'd0, 16'd6),      64'h8000_0000_0000_0000});
        br_tab.push_back('{enc_i(6'd1, 5'd1, 5'd0, 16'd3),      64'hFFFF_FFFF_FFFF_FFFB});
        br_tab.push_back('{enc_i(6'd1, 5'd1, 5'd0, 16'd3),      64'd0});
        br_tab.push_back('{enc_i(6'd1, 5'd1, 5'd1, 16'hFFF0),   64'd0});
        br_tab.push_back('{enc_i(6'd1, 5'd1, 5'd1, 16'd5),      64'hFFFF_FFFF_FFFF_FFFF});
        br_tab.push_back('{enc_i(6'd1, 5'd1, 5'd2, 16'd5),      64'hFFFF_FFFF_FFFF_FFFF});
        foreach (br_tab[i]) step("branch", 0, br_tab[i].in, 0, 0, 0, 0, br_tab[i].alu);

        step("jalr_ra",   0, enc_jr(5'd31, 6'h09), 0, 0, 1, 0, tgt(32'h0040_0600));
        step("stall_jal", 1, enc_j(6'd3, 32'h0040_0800), 0, 0, 0, 0, 64'd0);
        step("stall_jr",  1, jr_ra, 0, 1, 0, 0, tgt(32'h0040_0604));
        step("jr_nonra",  0, enc_jr(5'd1, 6'h08), 0, 1, 0, 0, tgt(32'hFFFF_FFFC));
        step("beq_wrap",  0, enc_i(6'd4, 5'd1, 5'd2, 16'd1), 0, 0, 0, 0, 64'd0);
        step("jr_back",   0, enc_jr(5'd1, 6'h08), 0, 1, 0, 0, tgt(32'h0040_0200));

        step("jr_misal",  0, enc_jr(5'd2, 6'h08), 0, 1, 0, 0, tgt(32'h0040_0002));
        step("misal_flt", 0, 32'd0, 0, 0, 0, 0, 64'd0);
        step("handler",   0, 32'd0, 0, 0, 0, 0, 64'd0);
        step("eret",      0, 32'd0, 0, 0, 0, 1, 64'd0);
        step("refault",   0, 32'd0, 0, 0, 0, 0, 64'd0);
        step("stall_eret", 1, 32'd0, 0, 0, 0, 1, 64'd0);
        step("excp_stall", 1, 32'd0, 1, 0, 0, 0, 64'd0);

        // ---- phase B: sticky-halt instance ----
        rst_n1 = 1'b0;
        rst_n0 = 1'b1;
        m_vec  = 1'b0;
        model_reset();
        push_expect();
        compare_out("reset_halt");

        for (int i = 0; i < 12; i++) step("nop_to_30", 0, 32'd0, 0, 0, 0, 0, 64'd0);
        step("excp_halt", 1, enc_j(6'd3, 32'h0040_0100), 1, 0, 0, 0, 64'd0);
        for (int i = 0; i < 10; i++)
            step("halt_hold", 1'($urandom), $urandom, 1'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom), {$urandom, $urandom});

        stall = 1'b0; inst = '0; cp_excp = 1'b0; is_jr = 1'b0; is_jalr = 1'b0;
        eret = 1'b0; alu_result = '0;
        #3;
        rst_n0 = 1'b0;
        #1;
        model_reset();
        push_expect();
        compare_out("async_rst");
        @(posedge clk_cpu);
        #1;
        rst_n0 = 1'b1;
        step("after_rst", 0, 32'd0, 0, 0, 0, 0, 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised next-generation program counter for the single-cycle MIPS core. It computes next-PC for sequential, branch, jump and jump-register flow.
- Adds stall support, an exception FSM with selectable halt/vector mode and EPC capture, and an eret return.
- Adds a return-address stack (RAS) that predicts jr $ra targets and counts mispredictions for performance monitoring.
- Sits between the decoder/ALU and instruction memory; drives the fetch address.

Parameters:
- AW, 32: PC/address width.
- DW, 64: alu_result width; jump-register target is alu_result[DW-1 -: AW].
- TEXT_START, 32'h0040_0000: reset PC.
- EXCP_ADDR, 32'h8000_0180: exception vector.
- EXCP_MODE, 0: 0 = sticky halt at EXCP_ADDR; 1 = vector, executing handler from EXCP_ADDR.
- RAS_DEPTH, 4: return-stack entries (power of two, ≥2).
- CNT_W, 16: miss-counter width.

Ports:
- clk_cpu  in  1  CPU clock.
- reset_n  in  1  asynchronous active-low reset.
- stall  in  1  hold PC and RAS this cycle.
- inst  in  32  current instruction.
- cp_excp  in  1  exception request from control path.
- is_jr  in  1  decoded R-type jr.
- is_jalr  in  1  decoded R-type jalr.
- eret  in  1  return from exception (EXCP_MODE=1 only).
- alu_result  in  DW  branch-compare value / jump-register target.
- pc  out  AW  current fetch address.
- epc  out  AW  PC of faulting instruction.
- halted  out  1  FSM in HALT.
- ras_pred  out  AW  top-of-stack prediction; 0 when the stack is empty.
- ras_valid  out  1  stack non-empty.
- ras_hit  out  1  one-cycle pulse: jr $ra target equals the popped entry.
- ras_miss_cnt  out  CNT_W  saturating misprediction count.

Behaviour:
- Reset (async, reset_n=0): pc=TEXT_START; epc=0; FSM=RUN; halted=0; RAS empty (ptr=0, count=0); ras_hit=0; ras_miss_cnt=0.
- next_addr=pc+4; brnc_addr=next_addr+sext(imm16)<<2; jmp_addr={pc[AW-1:28], inst[25:0], 2'b00}.
- RUN, priority high to low:
  1. cp_excp or pc[1:0]≠0 → pc←EXCP_ADDR, epc←pc. Next state: HALT if EXCP_MODE=0, else RUN. Applies even while stall=1.
  2. stall → all state holds; ras_hit=0.
  3. eret and EXCP_MODE=1 → pc←epc+4.
  4. Normal flow:
     - is_jr/is_jalr → target.
     - bltz (rt=0): signed<0; bgez (rt=1): ≥0; other rt → next_addr.
     - beq: ==0; bne: ≠0; blez: ≤0; bgtz: >0 → brnc_addr, else next_addr.
     - j/jal → jmp_addr.
     - Everything else → next_addr.
- HALT: pc holds EXCP_ADDR; all inputs ignored; only reset exits. halted=1 combinationally from state.
- RAS, updated only on a non-stalled, non-excepting RUN cycle:
  - Push next_addr on jal, and on jalr.
  - Pop on is_jr with inst[25:21]=31.
  - jalr never pops.
  - Push when full: circular overwrite of the oldest entry; count saturates at RAS_DEPTH.
  - Pop when count=0: counts as a miss; pointer and count unchanged.
  - On pop, compare the popped entry to the jr target: equal → ras_hit=1 next cycle; unequal → miss.
  - ras_miss_cnt saturates at all-ones.
  - Prediction does not redirect pc; the architectural target is always used.
- Exception does not flush the RAS.
- All arithmetic is modulo 2^AW; the branch at the top of the address space wraps.

Decomposition:
- Opcode, funct and field-slice constants (OP_*, I_OP, I_RT, I_RS, I_IMM, I_ADDR) stay in the shared defines.v.
- Add the FSM state enum (RUN, HALT) to the shared package.
- Sub-module ras_stack (params AW, RAS_DEPTH; ports push, pop, push_data, top, valid, pop_data). It is natural and separately testable.

Test Plan:
- Release reset_n, no stall, inst=nop → pc sequence 0x00400000, 0x00400004, 0x00400008.
- pc=0x00400010, beq with imm=0xFFFF, alu_result=0 → pc=0x00400010. With alu_result=5 → pc=0x00400014.
- jal at 0x00400020, then jr $31 with alu_result[63:32]=0x00400024 → ras_hit=1, miss_cnt=0. Repeat with target 0x00400100 → miss_cnt=1.
- 5 jal pushes with RAS_DEPTH=4, then 5 jr $31 pops → first 4 pops return the last 4 pushed addresses (LIFO); 5th pop is a miss; ras_valid=0.
- EXCP_MODE=0, cp_excp at pc=0x00400030 with stall=1 → pc=0x80000180, epc=0x00400030, halted=1; pc stays put for 10 cycles under any inst. reset_n low mid-halt → pc=0x00400000 immediately.
- EXCP_MODE=1, misaligned jr target 0x00400002 → next cycle pc=0x80000180, epc=0x00400002. eret → pc=0x00400006, which is misaligned, so a re-fault follows (documented boundary).
